// File: rtl/player_ctrl.sv
// player_ctrl: user-control front end for the PWM music player.
//
// Debounces the two board buttons and classifies each press as short or
// long. Runs the STOP/LOAD/PLAY/PAUSE transport state machine and drives the
// volume, the player's reset and the active-low status LEDs. Lives in the
// PLL output clock domain, between the board pins and the Player instance.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset (deassertion synchronised inside)
//   btn[1:0]     raw buttons, active-low; btn[0] = transport, btn[1] = volume/restart
//   track_done   one-cycle pulse from the player at end of track
//   player_reset active-high reset to the player (STOP and LOAD)
//   play_en      player run enable (PLAY only)
//   track_sel    selected track index
//   volume       volume level, wraps at the top
//   led          status LEDs, active-low: [LED_WIDTH-1]=PLAY, [LED_WIDTH-2]=PAUSE,
//                low bits show track_sel
module player_ctrl #(
  parameter int CLK_FREQ          = 50000000,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 40000000,
  parameter int NUM_TRACKS        = 4,
  parameter int VOLUME_BITS       = 3,
  parameter int VOL_RESET         = 4,
  parameter int RESET_CYCLES      = 4,
  parameter int AUTO_ADVANCE      = 1,
  parameter int LED_WIDTH         = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    btn,
  input  logic                          track_done,
  output logic                          player_reset,
  output logic                          play_en,
  output logic [$clog2(NUM_TRACKS)-1:0] track_sel,
  output logic [VOLUME_BITS-1:0]        volume,
  output logic [LED_WIDTH-1:0]          led
);

  localparam int TW     = $clog2(NUM_TRACKS);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int LOAD_W = $clog2(RESET_CYCLES + 1);

  // A degenerate debounce length or clock setting collapses to
  // "accept on the first differing cycle".
  localparam int DEB_LAST_I = (DEBOUNCE_CYCLES < 1 || CLK_FREQ < 1) ? 0 : DEBOUNCE_CYCLES - 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_LAST_I);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(RESET_CYCLES - 1);
  localparam logic [TW-1:0]     TRK_LAST  = TW'(NUM_TRACKS - 1);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_LOAD,
    ST_PLAY,
    ST_PAUSE
  } state_t;

  // Reset: asserts immediately, releases two clocks later so every flop
  // leaves reset on the same edge.
  logic rst_meta;
  logic rst_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  // Button synchronisers, debouncers and hold counters. Levels idle high
  // (released); the accepted level only moves after DEBOUNCE_CYCLES
  // consecutive cycles of the synchronised level disagreeing with it.
  logic [1:0]        sync_meta;
  logic [1:0]        sync_lvl;
  logic [1:0]        stable;
  logic [DEB_W-1:0]  deb_cnt  [2];
  logic [HOLD_W-1:0] hold_cnt [2];

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      sync_meta <= 2'b11;
      sync_lvl  <= 2'b11;
      stable    <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i]  <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      sync_meta <= btn;
      sync_lvl  <= sync_meta;
      for (int i = 0; i < 2; i++) begin
        if (sync_lvl[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
          stable[i]  <= sync_lvl[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end

        // Saturating at HOLD_MAX doubles as the "long already fired" flag.
        if (stable[i]) begin
          hold_cnt[i] <= '0;
        end else if (hold_cnt[i] != HOLD_MAX) begin
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [1:0] accept;
  logic [1:0] short_evt;
  logic [1:0] long_evt;

  always_comb begin
    accept    = 2'b00;
    short_evt = 2'b00;
    long_evt  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      accept[i]    = (sync_lvl[i] != stable[i]) && (deb_cnt[i] == DEB_LAST);
      long_evt[i]  = !stable[i] && (hold_cnt[i] == HOLD_LAST);
      // Release accepted and no long event for this press (earlier or now).
      short_evt[i] = accept[i] && !stable[i] && (hold_cnt[i] != HOLD_MAX) && !long_evt[i];
    end
  end

  function automatic logic [TW-1:0] next_track(input logic [TW-1:0] t);
    return (t == TRK_LAST) ? '0 : t + 1'b1;
  endfunction

  function automatic logic [LED_WIDTH-1:0] build_led(input state_t s, input logic [TW-1:0] t);
    logic [LED_WIDTH-1:0] l;
    l                = '1;
    l[LED_WIDTH-1]   = (s != ST_PLAY);
    l[LED_WIDTH-2]   = (s != ST_PAUSE);
    for (int i = 0; i < TW; i++) begin
      l[i] = ~t[i];
    end
    return l;
  endfunction

  // Transport FSM. Outputs are registered from the current state, so they
  // follow a state change one cycle later. Within one cycle btn0 events beat
  // btn1 long, which beats track_done; losers are simply dropped.
  state_t            state;
  logic [LOAD_W-1:0] load_cnt;

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state        <= ST_STOP;
      load_cnt     <= '0;
      track_sel    <= '0;
      volume       <= VOLUME_BITS'(VOL_RESET);
      play_en      <= 1'b0;
      player_reset <= 1'b1;
      led          <= '1;
    end else begin
      play_en      <= (state == ST_PLAY);
      player_reset <= (state == ST_STOP) || (state == ST_LOAD);
      led          <= build_led(state, track_sel);

      // Volume runs beside the FSM and is never blocked by it.
      if (short_evt[1]) begin
        volume <= volume + 1'b1;
      end

      case (state)
        ST_STOP: begin
          if (short_evt[0]) begin
            state    <= ST_LOAD;
            load_cnt <= '0;
          end else if (long_evt[0]) begin
            track_sel <= next_track(track_sel);
          end
        end
        ST_LOAD: begin
          if (load_cnt == LOAD_LAST) begin
            state <= ST_PLAY;
          end else begin
            load_cnt <= load_cnt + 1'b1;
          end
        end
        ST_PLAY: begin
          if (short_evt[0]) begin
            state <= ST_PAUSE;
          end else if (long_evt[0]) begin
            track_sel <= next_track(track_sel);
            state     <= ST_LOAD;
            load_cnt  <= '0;
          end else if (long_evt[1]) begin
            state    <= ST_LOAD;
            load_cnt <= '0;
          end else if (track_done) begin
            if (AUTO_ADVANCE != 0) begin
              track_sel <= next_track(track_sel);
              state     <= ST_LOAD;
              load_cnt  <= '0;
            end else begin
              state <= ST_STOP;
            end
          end
        end
        ST_PAUSE: begin
          if (short_evt[0]) begin
            state <= ST_PLAY;
          end else if (long_evt[0]) begin
            track_sel <= next_track(track_sel);
            state     <= ST_LOAD;
            load_cnt  <= '0;
          end else if (long_evt[1]) begin
            state    <= ST_LOAD;
            load_cnt <= '0;
          end
        end
        default: state <= ST_STOP;
      endcase
    end
  end

endmodule

// File: tb/tb_player_ctrl.sv
module tb_player_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn = 2'b11;
  logic       track_done = 1'b0;

  logic       pr_a, pe_a, pr_b, pe_b;
  logic [1:0] ts_a, ts_b;
  logic [2:0] vol_a, vol_b;
  logic [5:0] led_a, led_b;

  always #5 clk = ~clk;

  player_ctrl #(
    .DEBOUNCE_CYCLES(8), .LONG_PRESS_CYCLES(64), .NUM_TRACKS(4), .VOLUME_BITS(3),
    .VOL_RESET(6), .RESET_CYCLES(4), .AUTO_ADVANCE(1), .LED_WIDTH(6)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .track_done(track_done),
    .player_reset(pr_a), .play_en(pe_a), .track_sel(ts_a), .volume(vol_a), .led(led_a)
  );

  player_ctrl #(
    .DEBOUNCE_CYCLES(8), .LONG_PRESS_CYCLES(64), .NUM_TRACKS(4), .VOLUME_BITS(3),
    .VOL_RESET(6), .RESET_CYCLES(4), .AUTO_ADVANCE(0), .LED_WIDTH(6)
  ) dut_b (
    .clk(clk), .reset(reset), .btn(btn), .track_done(track_done),
    .player_reset(pr_b), .play_en(pe_b), .track_sel(ts_b), .volume(vol_b), .led(led_b)
  );

  typedef struct packed {
    logic       pr;
    logic       pe;
    logic [1:0] ts;
    logic [2:0] vol;
    logic [5:0] led;
  } obs_t;

  typedef struct {
    int   op;
    obs_t exp;
    int   pulse;  // expected cycles of player_reset high during the op, -1 = not checked
  } vec_t;

  localparam int OP_S0   = 0;
  localparam int OP_S1   = 1;
  localparam int OP_SB   = 2;
  localparam int OP_L0   = 3;
  localparam int OP_L1   = 4;
  localparam int OP_TD   = 5;
  localparam int OP_S0TD = 6;
  localparam int OP_GL   = 7;

  obs_t sb_q[$];
  vec_t tbl[24];
  int   n_vec = 0;
  int   n_err = 0;
  int   pr_cnt = 0;
  int   pr_first = -1;
  int   cyc = 0;

  function automatic obs_t mk(input logic pr, input logic pe, input logic [1:0] ts,
                              input logic [2:0] vol, input logic [5:0] led);
    return {pr, pe, ts, vol, led};
  endfunction

  function automatic obs_t obs_a();
    return {pr_a, pe_a, ts_a, vol_a, led_a};
  endfunction

  function automatic obs_t obs_b();
    return {pr_b, pe_b, ts_b, vol_b, led_b};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got pr=%b pe=%b ts=%0d vol=%0d led=%b, want pr=%b pe=%b ts=%0d vol=%0d led=%b",
               name, act.pr, act.pe, act.ts, act.vol, act.led,
               exp.pr, exp.pe, exp.ts, exp.vol, exp.led);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (pr_a) begin
      pr_cnt++;
      if (pr_first < 0) pr_first = cyc;
    end
  endtask

  task automatic press(input logic [1:0] mask, input int low);
    btn = ~mask;
    repeat (low) step();
    btn = 2'b11;
    repeat (25) step();
  endtask

  task automatic do_op(input int op);
    pr_cnt   = 0;
    pr_first = -1;
    cyc      = 0;
    case (op)
      OP_S0: press(2'b01, 20);
      OP_S1: press(2'b10, 20);
      OP_SB: press(2'b11, 20);
      OP_L0: press(2'b01, 100);
      OP_L1: press(2'b10, 100);
      OP_TD: begin
        track_done = 1'b1;
        step();
        track_done = 1'b0;
        repeat (25) step();
      end
      OP_S0TD: begin
        // The release is accepted on the 10th edge after it; track_done is
        // placed on exactly that edge.
        btn = 2'b10;
        repeat (20) step();
        btn = 2'b11;
        repeat (9) step();
        track_done = 1'b1;
        step();
        track_done = 1'b0;
        repeat (25) step();
      end
      default: begin
        repeat (4) begin
          btn = 2'b10;
          repeat (5) step();
          btn = 2'b11;
          repeat (3) step();
        end
        repeat (25) step();
      end
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    repeat (5) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t got;
    obs_t exp;
    bit   found;

    tbl[0]  = '{OP_S0,   mk(0, 1, 0, 6, 6'b011111), -1};
    tbl[1]  = '{OP_GL,   mk(0, 1, 0, 6, 6'b011111),  0};
    tbl[2]  = '{OP_L0,   mk(0, 1, 1, 6, 6'b011110),  4};
    tbl[3]  = '{OP_S0,   mk(0, 0, 1, 6, 6'b101110),  0};
    tbl[4]  = '{OP_S0,   mk(0, 1, 1, 6, 6'b011110),  0};
    tbl[5]  = '{OP_L0,   mk(0, 1, 2, 6, 6'b011101),  4};
    tbl[6]  = '{OP_L0,   mk(0, 1, 3, 6, 6'b011100),  4};
    tbl[7]  = '{OP_L0,   mk(0, 1, 0, 6, 6'b011111),  4};
    tbl[8]  = '{OP_L0,   mk(0, 1, 1, 6, 6'b011110),  4};
    tbl[9]  = '{OP_L0,   mk(0, 1, 2, 6, 6'b011101),  4};
    tbl[10] = '{OP_L0,   mk(0, 1, 3, 6, 6'b011100),  4};
    tbl[11] = '{OP_TD,   mk(0, 1, 0, 6, 6'b011111),  4};
    tbl[12] = '{OP_S1,   mk(0, 1, 0, 7, 6'b011111),  0};
    tbl[13] = '{OP_S1,   mk(0, 1, 0, 0, 6'b011111),  0};
    tbl[14] = '{OP_S0,   mk(0, 0, 0, 0, 6'b101111),  0};
    tbl[15] = '{OP_L1,   mk(0, 1, 0, 0, 6'b011111),  4};
    tbl[16] = '{OP_S0,   mk(0, 0, 0, 0, 6'b101111),  0};
    tbl[17] = '{OP_S0,   mk(0, 1, 0, 0, 6'b011111),  0};
    tbl[18] = '{OP_L1,   mk(0, 1, 0, 0, 6'b011111),  4};
    tbl[19] = '{OP_SB,   mk(0, 0, 0, 1, 6'b101111),  0};
    tbl[20] = '{OP_S0,   mk(0, 1, 0, 1, 6'b011111),  0};
    tbl[21] = '{OP_S0TD, mk(0, 0, 0, 1, 6'b101111),  0};
    tbl[22] = '{OP_S1,   mk(0, 0, 0, 2, 6'b101111),  0};
    tbl[23] = '{OP_S0,   mk(0, 1, 0, 2, 6'b011111),  0};

    // Power-up reset
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();
    check("reset_state_a", obs_a(), mk(1, 0, 0, 6, 6'b111111));
    check("reset_state_b", obs_b(), mk(1, 0, 0, 6, 6'b111111));
    reset = 1'b1;
    repeat (5) step();

    // Table-driven transport/volume sequence through a scoreboard queue
    for (int i = 0; i < 24; i++) begin
      sb_q.push_back(tbl[i].exp);
      do_op(tbl[i].op);
      got = obs_a();
      exp = sb_q.pop_front();
      check($sformatf("vec%0d", i), got, exp);
      if (tbl[i].pulse >= 0)
        check_int($sformatf("vec%0d_load_pulse", i), pr_cnt, tbl[i].pulse);
    end

    // Long press in PLAY: event latency, single load pulse, silent release
    do_op(OP_L0);
    n_vec++;
    if (pr_first < 72 || pr_first > 78) begin
      n_err++;
      $display("FAIL long_latency: got first reset at cycle %0d, want 72..78", pr_first);
    end
    check_int("long_pulse_len", pr_cnt, 4);
    check("long_then_release", obs_a(), mk(0, 1, 1, 2, 6'b011110));

    // End-of-track on the last track, with and without auto-advance
    do_reset();
    do_op(OP_S0);
    do_op(OP_L0);
    do_op(OP_L0);
    do_op(OP_L0);
    check("b_on_track3", obs_b(), mk(0, 1, 3, 6, 6'b011100));
    do_op(OP_TD);
    check("td_auto_advance", obs_a(), mk(0, 1, 0, 6, 6'b011111));
    check("td_to_stop", obs_b(), mk(1, 0, 3, 6, 6'b111100));

    // Reset in the middle of a LOAD pulse
    btn   = 2'b01;
    found = 1'b0;
    for (int k = 0; k < 150 && !found; k++) begin
      step();
      if (pr_a) found = 1'b1;
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL load_start_timeout: got no player_reset within 150 cycles, want a LOAD");
    end
    step();
    reset = 1'b0;
    #1;
    check("reset_mid_load", obs_a(), mk(1, 0, 0, 6, 6'b111111));
    btn = 2'b11;
    repeat (3) step();
    reset = 1'b1;
    repeat (5) step();

    // Reset while a hold count is about 40, button kept low afterwards
    do_op(OP_S0);
    btn = 2'b10;
    repeat (50) step();
    reset = 1'b0;
    #1;
    check("reset_mid_hold", obs_a(), mk(1, 0, 0, 6, 6'b111111));
    repeat (2) step();
    reset = 1'b1;
    repeat (30) step();
    check("no_event_after_reset", obs_a(), mk(1, 0, 0, 6, 6'b111111));
    btn = 2'b11;
    repeat (25) step();
    check("press_after_reset", obs_a(), mk(0, 1, 0, 6, 6'b011111));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
